// File: rtl/shift_seq_ctrl_if.sv
// Command/data bundle between a host and shift_seq_ctrl.
// abort/aborted exist only when SHIFT_ABORT_EN is defined.
interface shift_seq_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic             cmd_sin;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
`ifdef SHIFT_ABORT_EN
    logic             abort;
    logic             aborted;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_sin, pin, abort,
        input  cmd_ready, q, busy, done, aborted
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_sin, pin, abort,
        output cmd_ready, q, busy, done, aborted
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_cnt, cmd_sin, pin,
        input  cmd_ready, q, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, cmd_sin, pin,
        output cmd_ready, q, busy, done
    );
`endif
endinterface

// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit shift register: load/shl/shr/rotl, one step per clock.
// Optional SHIFT_ABORT_EN adds abort/aborted on the interface.
module shift_seq_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic            clk,
    input  logic            reset,
    shift_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
    typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SHL = 2'b01, OP_SHR = 2'b10, OP_ROTL = 2'b11} op_e;
    typedef struct packed {
        op_e              op;
        logic             sin;
        logic [WIDTH-1:0] pin;
    } cmd_t;

    state_e           state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             cmd_ready_q, cmd_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_req;

`ifdef SHIFT_ABORT_EN
    logic aborted_q, aborted_d;

    assign abort_req = bus.abort;

    always_comb begin
        aborted_d = (state_q == S_EXEC) && bus.abort;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) aborted_q <= 1'b0;
        else       aborted_q <= aborted_d;
    end

    assign bus.aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    // Next-state, datapath step and registered-output decode
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        rem_d   = rem_q;
        q_d     = q_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    cmd_d.op  = op_e'(bus.cmd_op);
                    cmd_d.sin = bus.cmd_sin;
                    cmd_d.pin = bus.pin;
                    if (op_e'(bus.cmd_op) == OP_LOAD) begin
                        rem_d   = CNT_W'(1);
                        state_d = S_EXEC;
                    end else if (bus.cmd_cnt != '0) begin
                        rem_d   = bus.cmd_cnt;
                        state_d = S_EXEC;
                    end else begin
                        rem_d   = '0;
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else begin
                    case (cmd_q.op)
                        OP_LOAD: q_d = cmd_q.pin;
                        OP_SHL:  q_d = {q_q[WIDTH-2:0], cmd_q.sin};
                        OP_SHR:  q_d = {cmd_q.sin, q_q[WIDTH-1:1]};
                        default: q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    endcase
                    rem_d = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            rem_q       <= '0;
            q_q         <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed test-plan sequence plus randomized commands
// against an arithmetic reference model. Builds with or without SHIFT_ABORT_EN.
module tb_shift_seq_ctrl;
    localparam int unsigned WIDTH  = 4;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned MAXCNT = (1 << CNT_W) - 1;
    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHL  = 2'd1;
    localparam logic [1:0] OP_SHR  = 2'd2;
    localparam logic [1:0] OP_ROTL = 2'd3;

    logic             clk = 1'b0;
    logic             reset;
    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH-1:0] mq;

    shift_seq_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
    shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] eq, input logic er,
                              input logic eb, input logic ed);
        check_eq({tag, ".q"},     32'(bus.q),         32'(eq));
        check_eq({tag, ".ready"}, 32'(bus.cmd_ready), 32'(er));
        check_eq({tag, ".busy"},  32'(bus.busy),      32'(eb));
        check_eq({tag, ".done"},  32'(bus.done),      32'(ed));
    endtask

    // One step of the register expressed as plain integer arithmetic
    function automatic logic [WIDTH-1:0] ref_step(input logic [1:0] op, input logic [WIDTH-1:0] cur,
                                                  input logic s, input logic [WIDTH-1:0] p);
        int unsigned v = 32'(cur);
        int unsigned m = 32'(1) << WIDTH;
        case (op)
            OP_LOAD: v = 32'(p);
            OP_SHL:  v = (v * 2 + 32'(s)) % m;
            OP_SHR:  v = v / 2 + 32'(s) * (m / 2);
            default: v = (v * 2) % m + v / (m / 2);
        endcase
        return WIDTH'(v);
    endfunction

    task automatic drive_noise();
        bus.cmd_valid = 1'($urandom);
        bus.cmd_op    = 2'($urandom);
        bus.cmd_cnt   = CNT_W'($urandom);
        bus.cmd_sin   = 1'($urandom);
        bus.pin       = WIDTH'($urandom);
    endtask

    // Issue one command from IDLE and check every cycle through DONE and back to IDLE
    task automatic run_cmd(input logic [1:0] op, input int unsigned cnt, input logic s,
                           input logic [WIDTH-1:0] p, input bit noise, input bit hold_load,
                           input logic [WIDTH-1:0] hold_pin);
        int unsigned steps;
        steps = (op == OP_LOAD) ? 1 : cnt;
        check_eq("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_cnt   = CNT_W'(cnt);
        bus.cmd_sin   = s;
        bus.pin       = p;
        @(posedge clk); #1;
        for (int i = 0; i < int'(steps); i++) begin
            check_outs("exec", mq, 1'b0, 1'b1, 1'b0);
            if (noise) drive_noise();
            else bus.cmd_valid = 1'b0;
            @(posedge clk); #1;
            mq = ref_step(op, mq, s, p);
        end
        check_outs("done", mq, 1'b0, 1'b1, 1'b1);
`ifdef SHIFT_ABORT_EN
        check_eq("aborted_normal", 32'(bus.aborted), 32'd0);
`endif
        if (hold_load) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = OP_LOAD;
            bus.pin       = hold_pin;
        end else begin
            bus.cmd_valid = 1'b0;
        end
        @(posedge clk); #1;
        check_outs("idle", mq, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] hp;
        bit               pend;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_cnt   = '0;
        bus.cmd_sin   = 1'b0;
        bus.pin       = '0;
`ifdef SHIFT_ABORT_EN
        bus.abort     = 1'b0;
`endif
        mq = '0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", '0, 1'b1, 1'b0, 1'b0);
`ifdef SHIFT_ABORT_EN
        check_eq("reset.aborted", 32'(bus.aborted), 32'd0);
`endif
        reset = 1'b0;
        @(posedge clk); #1;
        check_outs("idle_hold", '0, 1'b1, 1'b0, 1'b0);

        // Load with pin noise during EXEC
        run_cmd(OP_LOAD, 0, 1'b0, 4'b0101, 1'b1, 1'b0, '0);
        check_eq("load_const", 32'(bus.q), 32'h5);

        // Shift left by 2
        run_cmd(OP_LOAD, 0, 1'b0, 4'b0110, 1'b0, 1'b0, '0);
        run_cmd(OP_SHL, 2, 1'b1, '0, 1'b0, 1'b0, '0);
        check_eq("shl_const", 32'(bus.q), 32'hB);

        // Shift right by 3, then zero-count shift
        run_cmd(OP_LOAD, 0, 1'b0, 4'b1101, 1'b0, 1'b0, '0);
        run_cmd(OP_SHR, 3, 1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("shr_const", 32'(bus.q), 32'h1);
        run_cmd(OP_SHL, 0, 1'b1, '0, 1'b0, 1'b0, '0);
        check_eq("cnt0_const", 32'(bus.q), 32'h1);

        // Rotate by WIDTH restores, with command noise during EXEC
        run_cmd(OP_LOAD, 0, 1'b0, 4'b1101, 1'b0, 1'b0, '0);
        run_cmd(OP_ROTL, WIDTH, 1'b0, '0, 1'b1, 1'b0, '0);
        check_eq("rotl_const", 32'(bus.q), 32'hD);

        // Command held valid across DONE is taken in the next IDLE cycle
        run_cmd(OP_SHL, 1, 1'b1, '0, 1'b0, 1'b1, 4'b1010);
        run_cmd(OP_LOAD, 0, 1'b0, 4'b1010, 1'b0, 1'b0, '0);
        check_eq("held_const", 32'(bus.q), 32'hA);

        // Max count
        run_cmd(OP_SHR, MAXCNT, 1'b1, '0, 1'b0, 1'b0, '0);
        check_eq("max_const", 32'(bus.q), 32'hF);

        // Asynchronous reset in the middle of a shl by 7
        run_cmd(OP_LOAD, 0, 1'b0, 4'b1111, 1'b0, 1'b0, '0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SHL;
        bus.cmd_cnt   = CNT_W'(7);
        bus.cmd_sin   = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            mq = ref_step(OP_SHL, mq, 1'b0, '0);
        end
        check_outs("mid_exec", 4'b1100, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        mq = '0;
        check_outs("async_rst", '0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_outs("post_rst", '0, 1'b1, 1'b0, 1'b0);
        end

`ifdef SHIFT_ABORT_EN
        // Abort ignored in IDLE, honoured in EXEC
        run_cmd(OP_LOAD, 0, 1'b0, 4'b1111, 1'b0, 1'b0, '0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        check_outs("abort_idle", 4'b1111, 1'b1, 1'b0, 1'b0);
        check_eq("abort_idle.aborted", 32'(bus.aborted), 32'd0);
        bus.abort     = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = OP_SHL;
        bus.cmd_cnt   = CNT_W'(7);
        bus.cmd_sin   = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_outs("abort_step1", 4'b1110, 1'b0, 1'b1, 1'b0);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check_outs("abort_done", 4'b1110, 1'b0, 1'b1, 1'b1);
        check_eq("abort_done.aborted", 32'(bus.aborted), 32'd1);
        @(posedge clk); #1;
        check_outs("abort_idle2", 4'b1110, 1'b1, 1'b0, 1'b0);
        check_eq("abort_idle2.aborted", 32'(bus.aborted), 32'd0);
        mq = 4'b1110;
`endif

        // Randomized command stream
        pend = 1'b0;
        hp   = '0;
        for (int n = 0; n < 150; n++) begin
            logic [1:0]  op;
            int unsigned cnt;
            logic        s;
            logic [WIDTH-1:0] p;
            bit          hold;
            op   = 2'($urandom);
            cnt  = $urandom_range(MAXCNT, 0);
            s    = 1'($urandom);
            p    = WIDTH'($urandom);
            hold = ($urandom_range(7, 0) == 0);
            if (pend) begin
                op = OP_LOAD;
                p  = hp;
            end
            hp   = WIDTH'($urandom);
            pend = hold;
            run_cmd(op, cnt, s, p, 1'($urandom), hold, hp);
        end
        bus.cmd_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
